dff_bist: RTL and testbench



---
 rtl/dff_bist_pkg.sv | 28 ++
 rtl/dff_bist_patgen.sv | 40 ++++
 rtl/dff_bist.sv | 174 +++++++++++++++++
 tb/tb_dff_bist.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bist_pkg.sv
// ============================================================================
// Module  : dff_bist_pkg
// Purpose : Shared state encoding and sequence-length constants for dff_bist.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dff_bist_pkg;

  localparam int PAT_FIXED  = 4;
  localparam int TOGGLE_LEN = 4;
  localparam int DRAIN_LEN  = 2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_A     = 4'd1,
    S_RST_C     = 4'd2,
    S_PATTERN   = 4'd3,
    S_TOGGLE    = 4'd4,
    S_DRAIN     = 4'd5,
    S_FINAL_RST = 4'd6,
    S_FINAL_CHK = 4'd7,
    S_DONE      = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dff_bist_patgen.sv
// ============================================================================
// Module  : dff_bist_patgen
// Purpose : Maps a PATTERN step index to its data word (0, 1s, 55.., AA.., walking one).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dff_bist_patgen
  import dff_bist_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDTH-1:0]  pat_o
);

  logic [WIDTH-1:0] alt_55;

  always_comb begin
    alt_55 = '0;
    for (int i = 0; i < WIDTH; i += 2) begin
      alt_55[i] = 1'b1;
    end

    pat_o = '0;
    if (step_i == STEP_W'(1)) begin
      pat_o = '1;
    end else if (step_i == STEP_W'(2)) begin
      pat_o = alt_55;
    end else if (step_i == STEP_W'(3)) begin
      pat_o = ~alt_55;
    end else if (step_i >= STEP_W'(PAT_FIXED)) begin
      pat_o = WIDTH'(1) << (step_i - STEP_W'(PAT_FIXED));
    end
  end

endmodule

`default_nettype wire

// File: rtl/dff_bist.sv
// ============================================================================
// Module  : dff_bist
// Purpose : Hardware self-test sequencer for an array of D flops with Q/Qbar checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_D,
  output logic             dut_reset,
  input  logic [WIDTH-1:0] dut_Q,
  input  logic [WIDTH-1:0] dut_Qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       error_count
);

  localparam int CNT_W = $clog2(PAT_FIXED + WIDTH + RST_CYCLES + TOGGLE_LEN + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               v1_q, v2_q;
  logic [WIDTH-1:0]   e1_q, e2_q;

  logic [CNT_W-1:0]   pat_step;
  logic [WIDTH-1:0]   pat_val;
  logic               chk_en;
  logic               chk_fail;
  logic [WIDTH-1:0]   chk_exp;
  logic [7:0]         err_cnt_d;

  // Generator is looked up one step ahead so the value lands on dut_D in its own cycle.
  assign pat_step = (state_q == S_PATTERN) ? cnt_q + CNT_W'(1) : '0;

  dff_bist_patgen #(
    .WIDTH  (WIDTH),
    .STEP_W (CNT_W)
  ) u_patgen (
    .step_i (pat_step),
    .pat_o  (pat_val)
  );

  always_comb begin
    chk_en    = v2_q || (state_q == S_RST_C) || (state_q == S_FINAL_CHK);
    chk_exp   = v2_q ? e2_q : '0;
    chk_fail  = chk_en && ((dut_Q != chk_exp) || (dut_Qbar != ~chk_exp));
    err_cnt_d = error_count;
    if (chk_fail && (error_count != 8'hFF)) begin
      err_cnt_d = error_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
      dut_D       <= '0;
      dut_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= 8'd0;
    end else begin
      v2_q        <= v1_q;
      e2_q        <= e1_q;
      v1_q        <= 1'b0;
      done        <= 1'b0;
      error_count <= err_cnt_d;

      case (state_q)
        S_IDLE: begin
          dut_reset <= 1'b1;
          if (start) begin
            error_count <= 8'd0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            dut_reset   <= 1'b0;
            dut_D       <= '0;
            cnt_q       <= '0;
            state_q     <= S_RST_A;
          end
        end

        S_RST_A, S_FINAL_RST: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= (state_q == S_RST_A) ? S_RST_C : S_FINAL_CHK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RST_C: begin
          dut_reset <= 1'b1;
          dut_D     <= pat_val;
          v1_q      <= 1'b1;
          e1_q      <= pat_val;
          cnt_q     <= '0;
          state_q   <= S_PATTERN;
        end

        S_PATTERN: begin
          v1_q <= 1'b1;
          if (cnt_q == CNT_W'(PAT_FIXED + WIDTH - 1)) begin
            dut_D   <= ~dut_D;
            e1_q    <= ~dut_D;
            cnt_q   <= '0;
            state_q <= S_TOGGLE;
          end else begin
            dut_D <= pat_val;
            e1_q  <= pat_val;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_TOGGLE: begin
          if (cnt_q == CNT_W'(TOGGLE_LEN - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            dut_D <= ~dut_D;
            e1_q  <= ~dut_D;
            v1_q  <= 1'b1;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
            dut_reset <= 1'b0;
            dut_D     <= '0;
            cnt_q     <= '0;
            state_q   <= S_FINAL_RST;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_FINAL_CHK: begin
          // The final reset compare lands on this same edge, so pass uses the next count.
          dut_reset <= 1'b1;
          done      <= 1'b1;
          pass      <= (err_cnt_d == 8'd0);
          state_q   <= S_DONE;
        end

        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dff_bist.sv
// ============================================================================
// Module  : tb_dff_bist
// Purpose : Directed bench for dff_bist with a behavioural 8-flop array and fault modes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dff_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dut_D;
  logic       dut_reset;
  logic [7:0] dut_Q;
  logic [7:0] dut_Qbar;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] error_count;

  int         checks = 0;
  int         errors = 0;

  // 0 good, 1 bit3 stuck-at-0, 2 Qbar tied to Q, 3 reset pin floating (cell holds)
  int         fault_mode = 0;
  logic       preload = 1'b0;
  logic [7:0] ff_q;

  logic [7:0] seen [16];
  int         lat;
  logic       busy_at_e0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge dut_reset) begin
    if (preload && clk)
      ff_q <= 8'hFF;
    else if (!dut_reset && fault_mode != 3)
      ff_q <= 8'h00;
    else if (!dut_reset)
      ff_q <= ff_q;
    else
      ff_q <= dut_D;
  end

  assign dut_Q    = (fault_mode == 1) ? (ff_q & 8'hF7) : ff_q;
  assign dut_Qbar = (fault_mode == 2) ? dut_Q : ~dut_Q;

  dff_bist #(
    .WIDTH      (8),
    .RST_CYCLES (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dut_D       (dut_D),
    .dut_reset   (dut_reset),
    .dut_Q       (dut_Q),
    .dut_Qbar    (dut_Qbar),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .error_count (error_count)
  );

  // Pulses start, logs the PATTERN/TOGGLE words and the edge offset of done (-1 on timeout).
  task automatic do_run(input logic pre);
    @(negedge clk);
    start   = 1'b1;
    preload = pre;
    @(posedge clk);
    #1;
    busy_at_e0 = busy;
    lat = -1;
    @(negedge clk);
    start   = 1'b0;
    preload = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k >= 3 && k <= 18) seen[k-3] = dut_D;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut_D !== 8'h00)      begin errors++; $display("FAIL reset_dut_D got %h want 00", dut_D); end
    checks++; if (dut_reset !== 1'b0)   begin errors++; $display("FAIL reset_dut_reset got %b want 0", dut_reset); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0)        begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (error_count !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %h want 00", error_count); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dut_reset !== 1'b1)   begin errors++; $display("FAIL idle_dut_reset got %b want 1", dut_reset); end
  endtask

  task automatic test_good_run;
    logic [7:0] exp_seq [16];
    exp_seq = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h04, 8'h08,
                8'h10, 8'h20, 8'h40, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
    fault_mode = 0;
    do_run(1'b0);
    checks++; if (busy_at_e0 !== 1'b1) begin errors++; $display("FAIL good_busy_e0 got %b want 1", busy_at_e0); end
    checks++; if (lat != 24)           begin errors++; $display("FAIL good_latency got %0d want 24", lat); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seen[i] !== exp_seq[i]) begin
        errors++; $display("FAIL good_dut_D[%0d] got %h want %h", i, seen[i], exp_seq[i]);
      end
    end
    checks++; if (pass !== 1'b1)         begin errors++; $display("FAIL good_pass got %b want 1", pass); end
    checks++; if (error_count !== 8'd0)  begin errors++; $display("FAIL good_errcnt got %0d want 0", error_count); end
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL good_busy_done got %b want 1", busy); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL good_after_done got done=%b busy=%b want 0 0", done, busy);
    end
    checks++; if (pass !== 1'b1)         begin errors++; $display("FAIL good_pass_hold got %b want 1", pass); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fault(input int mode, input logic pre, input logic [7:0] want, input string name);
    fault_mode = mode;
    do_run(pre);
    checks++; if (lat != 24)           begin errors++; $display("FAIL %s_latency got %0d want 24", name, lat); end
    checks++; if (error_count !== want) begin errors++; $display("FAIL %s_errcnt got %0d want %0d", name, error_count, want); end
    checks++; if (pass !== 1'b0)       begin errors++; $display("FAIL %s_pass got %b want 0", name, pass); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort;
    int done_cnt;
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (dut_D !== 8'h04 || error_count !== 8'd2) begin
      errors++; $display("FAIL abort_pre got dut_D=%h err=%0d want 04 2", dut_D, error_count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (dut_D !== 8'h00)       begin errors++; $display("FAIL abort_dut_D got %h want 00", dut_D); end
    checks++; if (dut_reset !== 1'b0)    begin errors++; $display("FAIL abort_dut_reset got %b want 0", dut_reset); end
    checks++; if (error_count !== 8'd0)  begin errors++; $display("FAIL abort_errcnt got %0d want 0", error_count); end
    repeat (2) @(negedge clk);
    fault_mode = 0;
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt); end
    do_run(1'b0);
    checks++; if (lat != 24 || pass !== 1'b1 || error_count !== 8'd0) begin
      errors++; $display("FAIL abort_rerun got lat=%0d pass=%b err=%0d want 24 1 0", lat, pass, error_count);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_start_held;
    int first_done;
    int second_done;
    int busy_low;
    fault_mode = 0;
    first_done  = -1;
    second_done = -1;
    busy_low    = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (done && first_done < 0) first_done = k;
      else if (done) second_done = k;
      if (first_done < 0 && !busy) busy_low++;
      if (k == 25) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_idle got %b want 0", busy); end
      end
      if (k == 26) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy_restart got %b want 1", busy); end
      end
      if (second_done > 0) break;
    end
    checks++; if (busy_low != 0)     begin errors++; $display("FAIL held_busy_run got %0d low cycles want 0", busy_low); end
    checks++; if (first_done != 24)  begin errors++; $display("FAIL held_first_done got %0d want 24", first_done); end
    checks++; if (second_done != 50) begin errors++; $display("FAIL held_second_done got %0d want 50", second_done); end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_fault(1, 1'b0, 8'd5,  "stuck_bit3");
    test_fault(2, 1'b0, 8'd18, "qbar_tied");
    test_fault(3, 1'b1, 8'd2,  "rst_floating");
    test_abort();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
